vlc_prenorm: RTL
================

Name: vlc_prenorm

Overview:
- Upstream pre-normalisation stage for the linear-CORDIC vectoring divider pipeline; computes y/x.
- Accepts one signed dividend/divisor pair per valid/ready handshake and makes the divisor non-negative.
- Left-shifts the divisor one bit per cycle until |y| < 2·x, which brings the quotient into the CORDIC convergence range.
- Presents x/y/z (z = 0) to stage 0 with the shift exponent, sign, divide-by-zero and range flags for the post-scaler.

Parameters:
DATA_WIDTH, 32, width of x/y/z data words (signed two's complement)
CORDIC_QUAN, 16, fractional bits of the fixed-point format (carried for downstream; not used arithmetically here)
MAX_SHIFT, 15, maximum normalisation shift
SHIFT_W, 5, width of shift_out; must hold MAX_SHIFT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input pair valid
in_ready  out  1  block can accept a pair
x_in  in  DATA_WIDTH  divisor, signed
y_in  in  DATA_WIDTH  dividend, signed
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
x_out  out  DATA_WIDTH  normalised non-negative divisor
y_out  out  DATA_WIDTH  sign-adjusted dividend
z_out  out  DATA_WIDTH  initial angle accumulator, always 0
shift_out  out  SHIFT_W  applied left shift s; quotient = z_final·2^s
neg_out  out  1  inputs were negated (x_in < 0)
dz_out  out  1  divisor was zero
ovf_out  out  1  MAX_SHIFT reached with |y| still ≥ 2·x

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE, out_valid=0. All data outputs, shift_out and flags are 0. Reset overrides everything, including mid-NORM or HOLD; any in-flight pair is discarded.
- States IDLE, NORM, HOLD. in_ready=1 only in IDLE; there is no overlap between successive operations.
- IDLE, in_valid=1 at edge E0: capture the pair.
  - If x_in<0: xa=-x_in and ya=-y_in, neg=1. Negating the most-negative value saturates to the most-positive value.
  - Else xa=x_in, ya=y_in.
  - If x_in==0: dz=1, s=0, go directly to HOLD.
  - Otherwise go to NORM.
- NORM, each edge:
  - cont = (|ya| ≥ 2·xa) AND (s < MAX_SHIFT) AND (xa[DATA_WIDTH-2]==0). Compare in DATA_WIDTH+2 bits; |ya| saturates like the negation.
  - cont true: xa <= xa<<1, s <= s+1.
  - cont false: go to HOLD. Set ovf=1 iff |ya| ≥ 2·xa still holds.
- HOLD:
  - out_valid=1. x_out=xa, y_out=ya, z_out=0, shift_out=s, plus flags.
  - All outputs remain stable while out_ready=0.
  - On out_valid&&out_ready, return to IDLE and deassert out_valid.
- Latency: out_valid first high after edge E0+s+1 for x≠0, and after E0 for x=0.
- ya is never shifted.

Optional Feature:
- Macro VLC_PRENORM_PERF_EN.
- Defined:
  - Adds outputs op_cnt[31:0] and ovf_cnt[31:0].
  - op_cnt increments on each input handshake; ovf_cnt increments on each output handshake with ovf_out=1.
  - Both wrap at 2^32 and clear on reset.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- x=0x00010000, y=0x00008000 accepted at E0 -> out_valid after E0+1; x_out=0x00010000, y_out=0x00008000, z_out=0, s=0, neg=dz=ovf=0.
- x=0x00010000, y=0x000A0000 -> three shifts; x_out=0x00080000, s=3, out_valid after E0+4, y_out=0x000A0000.
- x=0xFFFE0000 (-2.0), y=0x00010000 -> neg=1, x_out=0x00020000, y_out=0xFFFF0000, s=0.
- x=0, y=0x00050000 -> dz=1, s=0, out_valid after E0; then x=1, y=0x7FFFFFFF -> s=15, x_out=0x00008000, ovf=1, out_valid after E0+16.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs unchanged, in_ready=0; assert out_ready -> in_ready=1 next cycle.
- Reset: assert rst_n=0 during NORM of the y=0x000A0000 case -> next cycle IDLE, out_valid=0, all outputs 0; a fresh pair then completes normally. With VLC_PRENORM_PERF_EN, after the sequence op_cnt and ovf_cnt match the counts of completed handshakes.

Source files
------------

// File: rtl/vlc_prenorm.sv
// Divisor pre-normalisation in front of the linear-CORDIC vectoring divider (y/x).
// Optional performance counters are enabled with `define VLC_PRENORM_PERF_EN.
module vlc_prenorm #(
   parameter int DATA_WIDTH  = 32,
   parameter int CORDIC_QUAN = 16,
   parameter int MAX_SHIFT   = 15,
   parameter int SHIFT_W     = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] x_in,
   input  logic [DATA_WIDTH-1:0] y_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] x_out,
   output logic [DATA_WIDTH-1:0] y_out,
   output logic [DATA_WIDTH-1:0] z_out,
   output logic [SHIFT_W-1:0]    shift_out,
   output logic                  neg_out,
   output logic                  dz_out,
   output logic                  ovf_out,
`ifdef VLC_PRENORM_PERF_EN
   output logic [31:0]           op_cnt,
   output logic [31:0]           ovf_cnt,
`endif
   output logic [1:0]            fsm_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high.
   // in_ready is high only in IDLE, out_valid only in HOLD; HOLD outputs stay frozen until taken.

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NORM = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0] MOST_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};

   if ((MAX_SHIFT >= (2 ** SHIFT_W)) || (CORDIC_QUAN >= DATA_WIDTH)) begin : g_bad_cfg
      $error("vlc_prenorm: SHIFT_W cannot hold MAX_SHIFT or CORDIC_QUAN too large");
   end

   logic [1:0]            state;
   logic [DATA_WIDTH-1:0] xa;
   logic [DATA_WIDTH-1:0] ya;
   logic [SHIFT_W-1:0]    s;
   logic                  neg;
   logic                  dz;
   logic                  ovf;

   // Two's complement negation that maps the most-negative code to the most-positive one.
   function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] v);
      if (v == MOST_NEG) return MOST_POS;
      return -v;
   endfunction

   logic [DATA_WIDTH-1:0] abs_ya;
   logic [DATA_WIDTH+1:0] abs_wide;
   logic [DATA_WIDTH+1:0] two_x;
   logic                  too_big;
   logic                  cont;

   always_comb begin
      abs_ya   = ya[DATA_WIDTH-1] ? sat_neg(ya) : ya;
      abs_wide = {2'b00, abs_ya};
      two_x    = {1'b0, xa, 1'b0};
      too_big  = (abs_wide >= two_x);
      // Stop before the divisor would reach the sign bit.
      cont     = too_big && (s < SHIFT_W'(MAX_SHIFT)) && !xa[DATA_WIDTH-2];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         xa    <= '0;
         ya    <= '0;
         s     <= '0;
         neg   <= 1'b0;
         dz    <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  s   <= '0;
                  ovf <= 1'b0;
                  dz  <= (x_in == '0);
                  neg <= x_in[DATA_WIDTH-1];
                  if (x_in[DATA_WIDTH-1]) begin
                     xa <= sat_neg(x_in);
                     ya <= sat_neg(y_in);
                  end else begin
                     xa <= x_in;
                     ya <= y_in;
                  end
                  state <= (x_in == '0) ? HOLD : NORM;
               end
            end
            NORM: begin
               if (cont) begin
                  xa <= xa << 1;
                  s  <= s + SHIFT_W'(1);
               end else begin
                  ovf   <= too_big;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign x_out     = xa;
   assign y_out     = ya;
   assign z_out     = '0;
   assign shift_out = s;
   assign neg_out   = neg;
   assign dz_out    = dz;
   assign ovf_out   = ovf;
   assign fsm_state = state;

`ifdef VLC_PRENORM_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_cnt  <= '0;
         ovf_cnt <= '0;
      end else begin
         if (in_valid && in_ready) op_cnt <= op_cnt + 32'd1;
         if (out_valid && out_ready && ovf) ovf_cnt <= ovf_cnt + 32'd1;
      end
   end
`endif

endmodule
